// File: rtl/pong_pixel_gen_if.sv
// Pixel-stream and game-control bundle between the VGA sync front end and pong_pixel_gen.
// slave = the pixel generator, master = whoever drives pixel coordinates and buttons.
interface pong_pixel_gen_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] rgb;
  logic [6:0]  hit_cnt;
  logic [1:0]  miss_cnt;
  logic        game_over;

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, btn_up, btn_down,
    input  rgb, hit_cnt, miss_cnt, game_over
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, btn_up, btn_down,
    output rgb, hit_cnt, miss_cnt, game_over
  );
endinterface

// File: rtl/pong_pixel_gen.sv
// Pong game state (ball, paddle, score FSM) and registered 12-bit pixel colour; ROUND_BALL_EN masks the ball to a circle.
// Latency: rgb is one clk behind pixel_x/pixel_y/video_on; game state advances on frame_tick, IDLE/OVER button exit on any clk.
// Backpressure: none, consumes one pixel per clk with no stall.
module pong_pixel_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int WALL_X_L     = 32,
  parameter int WALL_X_R     = 35,
  parameter int BAR_X_L      = 600,
  parameter int BAR_X_R      = 603,
  parameter int PADDLE_H     = 72,
  parameter int PADDLE_V     = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  pong_pixel_gen_if.slave  bus
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  // 11-bit copies so sums like ball_x+BALL_SIZE never wrap in compares
  localparam logic [10:0] X_WL      = 11'(WALL_X_L);
  localparam logic [10:0] X_WR      = 11'(WALL_X_R);
  localparam logic [10:0] X_BL      = 11'(BAR_X_L);
  localparam logic [10:0] X_BR      = 11'(BAR_X_R);
  localparam logic [10:0] PH_M1     = 11'(PADDLE_H - 1);
  localparam logic [10:0] BS_M1     = 11'(BALL_SIZE - 1);
  localparam logic [10:0] BS        = 11'(BALL_SIZE);
  localparam logic [10:0] BV        = 11'(BALL_V);
  localparam logic [10:0] Y_BOT     = 11'(V_ACTIVE - BALL_V);
  localparam logic [10:0] X_LEFT    = 11'(WALL_X_R + 1);
  localparam logic [10:0] MISS_EDGE = 11'(H_ACTIVE - 1 - BALL_V);
  localparam logic [10:0] PAD_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] PAD_SPAN  = 11'(PADDLE_H + PADDLE_V);
  localparam logic [9:0]  PV        = 10'(PADDLE_V);
  localparam logic [9:0]  PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0]  BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [6:0]  HIT_MAX   = 7'd99;

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, MISS, OVER} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  serve_cnt, serve_cnt_n;
  logic [9:0]     paddle_y, paddle_y_n;
  logic [9:0]     ball_x, ball_x_n, ball_y, ball_y_n;
  logic           dx_pos, dx_pos_n, dy_pos, dy_pos_n;
  logic [6:0]     hit_cnt, hit_cnt_n;
  logic [1:0]     miss_cnt, miss_cnt_n;
  logic [11:0]    rgb_q, color;

  logic        tick, btn_any;
  logic [10:0] bx_w, by_w, pad_w, px_w, py_w, ball_r;

  assign tick    = bus.frame_tick;
  assign btn_any = bus.btn_up | bus.btn_down;
  assign bx_w    = {1'b0, ball_x};
  assign by_w    = {1'b0, ball_y};
  assign pad_w   = {1'b0, paddle_y};
  assign px_w    = {1'b0, bus.pixel_x};
  assign py_w    = {1'b0, bus.pixel_y};
  assign ball_r  = bx_w + BS_M1;

  always_comb begin
    state_n     = state;
    serve_cnt_n = serve_cnt;
    paddle_y_n  = paddle_y;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dx_pos_n    = dx_pos;
    dy_pos_n    = dy_pos;
    hit_cnt_n   = hit_cnt;
    miss_cnt_n  = miss_cnt;

    case (state)
      IDLE: if (btn_any) state_n = SERVE;
      SERVE: if (tick) begin
        serve_cnt_n = serve_cnt + CNT_ONE;
        if (serve_cnt == SERVE_LAST) state_n = PLAY;
      end
      PLAY: if (tick) begin
        if (ball_r > MISS_EDGE) begin
          state_n = MISS;
        end else begin
          // next-frame velocity comes from the current position; later rules override earlier ones
          if (by_w <= BV) dy_pos_n = 1'b1;
          if (by_w + BS >= Y_BOT) dy_pos_n = 1'b0;
          if (bx_w <= X_LEFT) dx_pos_n = 1'b1;
          if (dx_pos && ball_r >= X_BL && ball_r <= X_BR &&
              by_w + BS_M1 >= pad_w && by_w <= pad_w + PH_M1) begin
            dx_pos_n = 1'b0;
            if (hit_cnt != HIT_MAX) hit_cnt_n = hit_cnt + 7'd1;
          end
          ball_x_n = dx_pos ? ball_x + 10'(BALL_V) : ball_x - 10'(BALL_V);
          ball_y_n = dy_pos ? ball_y + 10'(BALL_V) : ball_y - 10'(BALL_V);
        end
      end
      MISS: if (tick) begin
        miss_cnt_n = miss_cnt + 2'd1;
        state_n    = (miss_cnt == 2'd2) ? OVER : SERVE;
      end
      OVER: if (btn_any) begin
        hit_cnt_n  = '0;
        miss_cnt_n = '0;
        state_n    = SERVE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n == SERVE) begin
      ball_x_n = BALL_X0;
      ball_y_n = BALL_Y0;
      dx_pos_n = 1'b0;
      dy_pos_n = 1'b1;
      if (state != SERVE) serve_cnt_n = '0;
    end

    if (tick && state != OVER) begin
      if (bus.btn_up && !bus.btn_down && paddle_y >= PV)
        paddle_y_n = paddle_y - PV;
      else if (bus.btn_down && !bus.btn_up && pad_w + PAD_SPAN <= PAD_LIM)
        paddle_y_n = paddle_y + PV;
    end
  end

  logic in_wall, in_pad, in_box, ball_vis, ball_on;
  assign in_wall  = px_w >= X_WL && px_w <= X_WR;
  assign in_pad   = px_w >= X_BL && px_w <= X_BR && py_w >= pad_w && py_w <= pad_w + PH_M1;
  assign in_box   = px_w >= bx_w && px_w <= bx_w + BS_M1 && py_w >= by_w && py_w <= by_w + BS_M1;
  assign ball_vis = (state == SERVE) || (state == PLAY) || (state == MISS);

`ifdef ROUND_BALL_EN
  logic [2:0] ball_row, ball_col;
  logic [7:0] rom_bits;
  assign ball_row = bus.pixel_y[2:0] - ball_y[2:0];
  assign ball_col = bus.pixel_x[2:0] - ball_x[2:0];

  always_comb begin
    case (ball_row)
      3'd0, 3'd7: rom_bits = 8'h3C;
      3'd1, 3'd6: rom_bits = 8'h7E;
      default:    rom_bits = 8'hFF;
    endcase
  end

  assign ball_on = ball_vis && in_box && rom_bits[3'd7 - ball_col];
`else
  assign ball_on = ball_vis && in_box;
`endif

  always_comb begin
    color = 12'h000;
    if (!bus.video_on) color = 12'h000;
    else if (in_wall)  color = 12'h00F;
    else if (in_pad)   color = 12'h0F0;
    else if (ball_on)  color = 12'hF00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      serve_cnt <= '0;
      paddle_y  <= PADDLE_Y0;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_pos    <= 1'b0;
      dy_pos    <= 1'b1;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      rgb_q     <= '0;
    end else begin
      state     <= state_n;
      serve_cnt <= serve_cnt_n;
      paddle_y  <= paddle_y_n;
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      dx_pos    <= dx_pos_n;
      dy_pos    <= dy_pos_n;
      hit_cnt   <= hit_cnt_n;
      miss_cnt  <= miss_cnt_n;
      rgb_q     <= color;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.hit_cnt   = hit_cnt;
  assign bus.miss_cnt  = miss_cnt;
  assign bus.game_over = (state == OVER);

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Bench for pong_pixel_gen: constant pixel table, hand sequences for serve/paddle/game-over, and a
// frame-level game model driving tracked/random play with rgb probes around the ball and paddle.
module tb_pong_pixel_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_pixel_gen_if bus();
  pong_pixel_gen dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4;

  // game model, kept in screen coordinates with signed velocities
  int m_st, m_cnt, m_py, m_bx, m_by, m_dx, m_dy, m_hit, m_miss;
  int half_w[8] = '{2, 1, 0, 0, 0, 0, 1, 2};

  typedef struct {
    bit vo;
    int px;
    int py;
    int want;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_py = 204;
    m_bx = 316; m_by = 236; m_dx = -2; m_dy = 2;
    m_hit = 0; m_miss = 0;
  endtask

  function automatic int model_rgb(input int px, input int py, input bit vo);
    int r, c;
    if (!vo) return 'h000;
    if (px >= 32 && px <= 35) return 'h00F;
    if (px >= 600 && px <= 603 && py >= m_py && py < m_py + 72) return 'h0F0;
    if ((m_st == S_SERVE || m_st == S_PLAY || m_st == S_MISS) &&
        px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) begin
      r = py - m_by;
      c = px - m_bx;
`ifdef ROUND_BALL_EN
      if (c < half_w[r] || c > 7 - half_w[r]) return 'h000;
`else
      if (r < 0 || c < 0) return 'h000;
`endif
      return 'hF00;
    end
    return 'h000;
  endfunction

  task automatic model_clk(input bit tick, input bit up, input bit dn);
    int ns, ndx, ndy;
    ns = m_st;
    if ((m_st == S_IDLE || m_st == S_OVER) && (up || dn)) begin
      ns = S_SERVE;
      m_cnt = 0;
      if (m_st == S_OVER) begin m_hit = 0; m_miss = 0; end
    end
    if (tick) begin
      if (m_st == S_SERVE) begin
        m_cnt++;
        if (m_cnt == 60) ns = S_PLAY;
      end else if (m_st == S_PLAY) begin
        if (m_bx + 7 > 637) ns = S_MISS;
        else begin
          ndx = m_dx; ndy = m_dy;
          if (m_by <= 2) ndy = 2;
          if (m_by + 8 >= 478) ndy = -2;
          if (m_bx <= 36) ndx = 2;
          if (m_bx + 7 >= 600 && m_bx + 7 <= 603 && m_by + 7 >= m_py && m_by <= m_py + 71 && m_dx > 0) begin
            ndx = -2;
            if (m_hit < 99) m_hit++;
          end
          m_bx = (m_bx + m_dx) & 1023;
          m_by = (m_by + m_dy) & 1023;
          m_dx = ndx; m_dy = ndy;
        end
      end else if (m_st == S_MISS) begin
        m_miss++;
        ns = (m_miss == 3) ? S_OVER : S_SERVE;
        m_cnt = 0;
      end
      if (m_st != S_OVER) begin
        if (up && !dn && m_py >= 4) m_py -= 4;
        else if (dn && !up && m_py + 76 <= 480) m_py += 4;
      end
    end
    if (ns == S_SERVE) begin
      m_bx = 316; m_by = 236; m_dx = -2; m_dy = 2;
    end
    m_st = ns;
  endtask

  // one clk: drive, let the DUT and model take the edge, sample 1 time unit later
  task automatic cyc(input bit tick, input bit up, input bit dn, input int px_in, input int py_in,
                     input bit vo, output int got, output int exp);
    int px, py;
    px = px_in & 1023;
    py = py_in & 1023;
    bus.frame_tick = tick;
    bus.btn_up     = up;
    bus.btn_down   = dn;
    bus.pixel_x    = px[9:0];
    bus.pixel_y    = py[9:0];
    bus.video_on   = vo;
    exp = model_rgb(px, py, vo);
    @(posedge clk);
    model_clk(tick, up, dn);
    #1;
    got = int'(bus.rgb);
    check("counters", int'({bus.game_over, bus.miss_cnt, bus.hit_cnt}),
          int'({m_st == S_OVER, 2'(m_miss), 7'(m_hit)}));
  endtask

  task automatic mcheck(input string name, input bit tick, input bit up, input bit dn,
                        input int px, input int py, input bit vo);
    int got, exp;
    cyc(tick, up, dn, px, py, vo, got, exp);
    check(name, got, exp);
  endtask

  task automatic kcheck(input string name, input int px, input int py, input bit vo, input int want);
    int got, exp;
    cyc(1'b0, 1'b0, 1'b0, px, py, vo, got, exp);
    check(name, got, want);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_rgb", int'(bus.rgb), 0);
    check("reset_counters", int'({bus.game_over, bus.miss_cnt, bus.hit_cnt}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int frames;
    bit up, dn;
    vecs = '{
      '{1'b1, 33, 100, 'h00F}, '{1'b0, 33, 100, 'h000}, '{1'b1, 32, 0, 'h00F},
      '{1'b1, 35, 479, 'h00F}, '{1'b1, 36, 100, 'h000}, '{1'b1, 31, 100, 'h000},
      '{1'b1, 600, 204, 'h0F0}, '{1'b1, 603, 275, 'h0F0}, '{1'b1, 600, 203, 'h000},
      '{1'b1, 600, 276, 'h000}, '{1'b1, 604, 240, 'h000}, '{1'b1, 319, 239, 'h000}
    };
    bus.frame_tick = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0;
    apply_reset();

    // static picture in IDLE: wall, paddle at reset position, ball hidden
    for (int i = 0; i < 12; i++) kcheck("idle_table", vecs[i].px, vecs[i].py, vecs[i].vo, vecs[i].want);

    // serve: ball held 60 frames at centre, moves on the 61st
    mcheck("serve_enter", 1'b0, 1'b1, 1'b0, 319, 239, 1'b1);
    kcheck("serve_ball", 319, 239, 1'b1, 'hF00);
    for (int i = 0; i < 59; i++) mcheck("serve_hold", 1'b1, 1'b0, 1'b0, 319, 239, 1'b1);
    kcheck("serve_59", 322, 240, 1'b1, 'hF00);
    mcheck("serve_60", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    kcheck("play_unmoved", 322, 240, 1'b1, 'hF00);
    mcheck("play_first", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    kcheck("play_old_pos", 322, 240, 1'b1, 'h000);
    kcheck("play_new_pos", 317, 241, 1'b1, 'hF00);

    // tracked then abandoned play until three misses end the game
    frames = 0;
    while (m_st != S_OVER && frames < 6000) begin
      up = 1'b0; dn = 1'b0;
      if (frames < 900) begin
        up = (m_by + 4) < (m_py + 36 - 4);
        dn = (m_by + 4) > (m_py + 36 + 4);
        if ($urandom_range(0, 9) == 0) {up, dn} = 2'($urandom_range(0, 3));
      end
      mcheck("play_tick", 1'b1, up, dn, m_bx + $urandom_range(0, 9) - 1, m_by + $urandom_range(0, 9) - 1,
             $urandom_range(0, 9) != 0);
      if (m_st == S_OVER) break;
      mcheck("ball_probe", 1'b0, up, dn, m_bx + $urandom_range(0, 9) - 1, m_by + $urandom_range(0, 9) - 1,
             $urandom_range(0, 9) != 0);
      mcheck("paddle_probe", 1'b0, up, dn, 596 + $urandom_range(0, 11), m_py + $urandom_range(0, 75) - 2, 1'b1);
      frames++;
    end
    check("game_over_reached", int'(bus.game_over), 1);
    check("over_miss_cnt", int'(bus.miss_cnt), 3);
    check("hits_seen", int'(bus.hit_cnt != 0), 1);
    kcheck("over_ball_hidden", 319, 239, 1'b1, 'h000);

    mcheck("over_exit", 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check("restart_counters", int'({bus.game_over, bus.miss_cnt, bus.hit_cnt}), 0);
    kcheck("restart_ball", 319, 239, 1'b1, 'hF00);

    // asynchronous reset mid-frame with a lit pixel in the output register
    kcheck("pre_reset_wall", 33, 100, 1'b1, 'h00F);
    #2;
    apply_reset();

    // paddle: both buttons hold position, btn_up alone clamps at the top
    for (int i = 0; i < 10; i++) mcheck("both_btns", 1'b1, 1'b1, 1'b1, 600, 204, 1'b1);
    kcheck("pad_both_top", 600, 204, 1'b1, 'h0F0);
    kcheck("pad_both_above", 600, 203, 1'b1, 'h000);
    kcheck("pad_both_bot", 600, 275, 1'b1, 'h0F0);
    kcheck("pad_both_below", 600, 276, 1'b1, 'h000);
    for (int i = 0; i < 60; i++) mcheck("up_held", 1'b1, 1'b1, 1'b0, 601, $urandom_range(0, 479), 1'b1);
    kcheck("pad_top_row", 600, 0, 1'b1, 'h0F0);
    kcheck("pad_top_last", 600, 71, 1'b1, 'h0F0);
    kcheck("pad_top_below", 600, 72, 1'b1, 'h000);
    kcheck("pad_no_wrap", 600, 476, 1'b1, 'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
